// File: rtl/bus_cycle_dtack_gen_if.sv
// CPU-side bus-cycle signals between the address decoder/CPU (master) and the DTACK/BERR terminator (slave).
// Carries selects, strobes and the registered acknowledge outputs.
interface bus_cycle_dtack_gen_if #(
   parameter int NUM_CH = 4
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              AS_b;
   logic [NUM_CH-1:0] CS_b;
   logic              WAIT_b;
   logic              SLOT;
   logic              DTACK_b;
   logic              BERR_b;
   logic              BUSY;
   logic [CH_W-1:0]   ACTIVE_CH;

   modport master (
      output AS_b, CS_b, WAIT_b, SLOT,
      input  DTACK_b, BERR_b, BUSY, ACTIVE_CH
   );

   modport slave (
      input  AS_b, CS_b, WAIT_b, SLOT,
      output DTACK_b, BERR_b, BUSY, ACTIVE_CH
   );
endinterface

// File: rtl/bus_cycle_dtack_gen.sv
// 68000 bus-cycle terminator: per-channel wait states, optional video-slot sync, BERR_b on timeout.
// Outputs registered from next state; WAIT_b low stalls the wait count, AS_b high aborts or ends the cycle.
module bus_cycle_dtack_gen #(
   parameter int                       NUM_CH      = 4,
   parameter int                       WAIT_W      = 4,
   parameter logic [NUM_CH*WAIT_W-1:0] WAIT_CYCLES = {4'd3, 4'd1, 4'd0, 4'd0},
   parameter logic [NUM_CH-1:0]        SLOT_MASK   = 4'b0100,
   parameter int                       TIMEOUT     = 64
) (
   input  logic                 MCKR,
   input  logic                 SYSRES_b,
   bus_cycle_dtack_gen_if.slave bus
);
   localparam int              CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int              TW    = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      SLOT_WAIT,
      UNMAPPED,
      ACK,
      ERR
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [TW-1:0]     timer_q, timer_d, timer_inc;
   logic [CH_W-1:0]   ch_q, ch_d, ch_sel;
   logic              slot_q;
   logic              slot_rise;
   logic              timeout;
   logic              any_sel;
   logic              dtack_b_q, berr_b_q, busy_q;

   function automatic logic [WAIT_W-1:0] wait_of(input logic [CH_W-1:0] c);
      return WAIT_CYCLES[int'(c)*WAIT_W +: WAIT_W];
   endfunction

   // Lowest-index asserted select has priority.
   always_comb begin
      ch_sel = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (!bus.CS_b[i]) ch_sel = CH_W'(i);
      end
   end

   assign any_sel   = ~&bus.CS_b;
   assign slot_rise = bus.SLOT & ~slot_q;
   assign timeout   = (timer_q == TLAST);
   assign timer_inc = (&timer_q) ? timer_q : timer_q + TW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      ch_d    = ch_q;
      case (state_q)
         IDLE: begin
            if (!bus.AS_b) begin
               timer_d = '0;
               if (any_sel) begin
                  ch_d    = ch_sel;
                  cnt_d   = wait_of(ch_sel);
                  state_d = COUNT;
               end else begin
                  state_d = UNMAPPED;
               end
            end
         end
         COUNT: begin
            timer_d = timer_inc;
            // Completion beats a coinciding timeout; a pending slot wait does not.
            if (bus.AS_b) begin
               state_d = IDLE;
            end else if (bus.WAIT_b && (cnt_q == '0) && !SLOT_MASK[ch_q]) begin
               state_d = ACK;
            end else if (timeout) begin
               state_d = ERR;
            end else if (bus.WAIT_b) begin
               if (cnt_q != '0) cnt_d = cnt_q - WAIT_W'(1);
               else             state_d = SLOT_WAIT;
            end
         end
         SLOT_WAIT: begin
            timer_d = timer_inc;
            if (bus.AS_b)      state_d = IDLE;
            else if (slot_rise) state_d = ACK;
            else if (timeout)   state_d = ERR;
         end
         UNMAPPED: begin
            timer_d = timer_inc;
            if (bus.AS_b)     state_d = IDLE;
            else if (timeout) state_d = ERR;
         end
         ACK, ERR: begin
            if (bus.AS_b) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge MCKR) begin
      if (!SYSRES_b) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         timer_q   <= '0;
         ch_q      <= '0;
         slot_q    <= 1'b1;
         dtack_b_q <= 1'b1;
         berr_b_q  <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timer_q   <= timer_d;
         ch_q      <= ch_d;
         slot_q    <= bus.SLOT;
         dtack_b_q <= (state_d != ACK);
         berr_b_q  <= (state_d != ERR);
         busy_q    <= (state_d != IDLE);
      end
   end

   assign bus.DTACK_b   = dtack_b_q;
   assign bus.BERR_b    = berr_b_q;
   assign bus.BUSY      = busy_q;
   assign bus.ACTIVE_CH = ch_q;
endmodule

// File: tb/tb_bus_cycle_dtack_gen.sv
// Bench for bus_cycle_dtack_gen: vector table, reset corner sequences and random bus cycles
// checked every edge against a transaction-level timing model.
module tb_bus_cycle_dtack_gen;
   logic MCKR;
   logic SYSRES_b;
   int   n_cmp;
   int   n_err;
   int   last_ch;

   bus_cycle_dtack_gen_if #(.NUM_CH(4)) bus ();

   // Board wait counts: ch0=0, ch1=1, ch2=0 (slot-synchronised), ch3=3.
   bus_cycle_dtack_gen #(
      .NUM_CH      (4),
      .WAIT_W      (4),
      .WAIT_CYCLES ({4'd3, 4'd0, 4'd1, 4'd0}),
      .SLOT_MASK   (4'b0100),
      .TIMEOUT     (64)
   ) dut (
      .MCKR     (MCKR),
      .SYSRES_b (SYSRES_b),
      .bus      (bus.slave)
   );

   initial MCKR = 1'b0;
   always #5 MCKR = ~MCKR;

   typedef struct {
      logic [3:0]  cs;
      int          L;
      logic [15:0] spat;
      int          A;
      int          H;
      int          D;
      int          kind;   // 0 none, 1 DTACK, 2 BERR
      int          ch;
   } vec_t;

   vec_t vt[13];

   function automatic int w_of(input int c);
      case (c)
         1:       return 1;
         3:       return 3;
         default: return 0;
      endcase
   endfunction

   function automatic logic [4:0] got_v();
      return {bus.DTACK_b, bus.BERR_b, bus.BUSY, bus.ACTIVE_CH};
   endfunction

   task automatic step();
      @(posedge MCKR);
      #1;
   endtask

   task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: {DTACK_b,BERR_b,BUSY,ACTIVE_CH} got %b required %b", nm, got, exp);
      end
   endtask

   // One bus cycle starting at j=0; outputs checked after every edge j.
   task automatic run_cycle(input logic [3:0] cs, input int L, input logic [127:0] sp,
                            input int A, input int H, input int D, input int kind,
                            input int ch, input string tag);
      int R;
      logic [4:0] exp;
      R = (kind == 0) ? A : D + 1 + H;
      for (int j = 0; j <= R; j++) begin
         bus.AS_b   = (j == R);
         bus.CS_b   = (j == 0) ? cs : 4'($urandom);
         bus.WAIT_b = !(j >= 1 && j <= L);
         bus.SLOT   = (j < 128) ? sp[j] : 1'b0;
         step();
         exp = {!(kind == 1 && j >= D && j < R), !(kind == 2 && j >= D && j < R),
                (j < R), 2'(ch)};
         chk($sformatf("%s j=%0d", tag, j), got_v(), exp);
      end
      bus.AS_b   = 1'b1;
      bus.WAIT_b = 1'b1;
      bus.SLOT   = 1'b0;
      step();
      chk($sformatf("%s gap", tag), got_v(), {1'b1, 1'b1, 1'b0, 2'(ch)});
      last_ch = ch;
   endtask

   initial begin
      logic [3:0]   cs;
      logic [127:0] sp;
      int c, L, e, D, kind, A, H;

      n_cmp = 0;
      n_err = 0;
      last_ch = 0;

      vt[0]  = '{4'b0111, 0,  16'h0000, -1, 2, 4,  1, 3};
      vt[1]  = '{4'b1110, 0,  16'h0000, -1, 1, 1,  1, 0};
      vt[2]  = '{4'b0101, 2,  16'h0000, -1, 1, 4,  1, 1};
      vt[3]  = '{4'b1011, 0,  16'h0020, -1, 1, 5,  1, 2};
      vt[4]  = '{4'b1011, 0,  16'h004F, -1, 1, 6,  1, 2};
      vt[5]  = '{4'b1011, 3,  16'h0084, -1, 1, 7,  1, 2};
      vt[6]  = '{4'b1111, 0,  16'h0000, -1, 1, 64, 2, 2};
      vt[7]  = '{4'b1011, 0,  16'h0000, -1, 2, 64, 2, 2};
      vt[8]  = '{4'b0111, 0,  16'h0000, 2,  0, 0,  0, 3};
      vt[9]  = '{4'b1110, 70, 16'h0000, -1, 1, 64, 2, 0};
      vt[10] = '{4'b0111, 60, 16'h0000, -1, 1, 64, 1, 3};
      vt[11] = '{4'b1011, 63, 16'h0000, -1, 1, 64, 2, 2};
      vt[12] = '{4'b1111, 0,  16'h0000, 10, 0, 0,  0, 2};

      // Reset held with an access pending.
      SYSRES_b   = 1'b0;
      bus.AS_b   = 1'b0;
      bus.CS_b   = 4'b1110;
      bus.WAIT_b = 1'b1;
      bus.SLOT   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("reset %0d", i), got_v(), 5'b11000);
      end
      SYSRES_b = 1'b1;
      run_cycle(4'b1110, 0, '0, -1, 1, 1, 1, 0, "rst_release");

      for (int i = 0; i < 13; i++) begin
         run_cycle(vt[i].cs, vt[i].L, {112'd0, vt[i].spat}, vt[i].A, vt[i].H,
                   vt[i].D, vt[i].kind, vt[i].ch, $sformatf("vec%0d", i));
      end

      // Reset while DTACK_b is asserted drops it on the same edge.
      bus.AS_b   = 1'b0;
      bus.CS_b   = 4'b0111;
      bus.WAIT_b = 1'b1;
      bus.SLOT   = 1'b0;
      for (int j = 0; j <= 4; j++) begin
         step();
         if (j == 3) chk("rst_ack pre", got_v(), 5'b11111);
      end
      chk("rst_ack ack", got_v(), 5'b01111);
      SYSRES_b = 1'b0;
      step();
      chk("rst_ack drop", got_v(), 5'b11000);
      SYSRES_b = 1'b1;
      bus.AS_b = 1'b1;
      step();
      chk("rst_ack idle", got_v(), 5'b11000);
      last_ch = 0;

      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(0, 3) == 0) cs = 4'hF;
         else begin
            cs = 4'($urandom);
            if (cs == 4'hF) cs = 4'hB;
         end
         c = last_ch;
         for (int i = 3; i >= 0; i--) if (!cs[i]) c = i;
         L = ($urandom_range(0, 7) == 0) ? $urandom_range(55, 70) : $urandom_range(0, 9);
         for (int i = 0; i < 128; i++) sp[i] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) sp = '0;

         if (cs == 4'hF) begin
            kind = 2;
            D = 64;
         end else begin
            e = 1 + w_of(c) + L;
            if (c != 2) begin
               if (e <= 64) begin kind = 1; D = e; end
               else         begin kind = 2; D = 64; end
            end else begin
               D = -1;
               for (int j = e + 1; j <= 64; j++)
                  if (D < 0 && sp[j] && !sp[j-1]) D = j;
               if (D < 0) begin kind = 2; D = 64; end
               else kind = 1;
            end
         end
         A = -1;
         if ($urandom_range(0, 4) == 0) begin
            A = $urandom_range(1, D + 3);
            if (A <= D) kind = 0;
         end
         H = $urandom_range(0, 3);
         run_cycle(cs, L, sp, A, H, D, kind, c, $sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
